// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared types and constants for the AXI read arbiter
package axi_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  localparam int ID_IFU = 0;
  localparam int ID_LSU = 1;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  typedef enum logic {M_IFU, M_LSU} master_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 write-channel bundle (AW/W/B) carried through the arbiter
interface axi_rd_arbiter_if;
  import axi_arb_pkg::*;

  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin IFU/LSU AXI4 read arbiter, one read outstanding,
// with LSU write channels passed straight through.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = axi_arb_pkg::ADDR_W,
  parameter int DATA_W = axi_arb_pkg::DATA_W,
  parameter int ID_W   = axi_arb_pkg::ID_W
) (
  input  logic              i_clock,
  input  logic              i_reset,

  input  logic [ADDR_W-1:0] i_ifu_araddr,
  input  logic [7:0]        i_ifu_arlen,
  input  logic [2:0]        i_ifu_arsize,
  input  logic [1:0]        i_ifu_arburst,
  input  logic              i_ifu_arvalid,
  output logic              o_ifu_arready,
  output logic [DATA_W-1:0] o_ifu_rdata,
  output logic [1:0]        o_ifu_rresp,
  output logic              o_ifu_rlast,
  output logic              o_ifu_rvalid,
  input  logic              i_ifu_rready,

  input  logic [ADDR_W-1:0] i_lsu_araddr,
  input  logic [7:0]        i_lsu_arlen,
  input  logic [2:0]        i_lsu_arsize,
  input  logic [1:0]        i_lsu_arburst,
  input  logic              i_lsu_arvalid,
  output logic              o_lsu_arready,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic [1:0]        o_lsu_rresp,
  output logic              o_lsu_rlast,
  output logic              o_lsu_rvalid,
  input  logic              i_lsu_rready,

  output logic [ADDR_W-1:0] o_axi_araddr,
  output logic [ID_W-1:0]   o_axi_arid,
  output logic [7:0]        o_axi_arlen,
  output logic [2:0]        o_axi_arsize,
  output logic [1:0]        o_axi_arburst,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,
  input  logic [DATA_W-1:0] i_axi_rdata,
  input  logic [1:0]        i_axi_rresp,
  input  logic [ID_W-1:0]   i_axi_rid,
  input  logic              i_axi_rlast,
  input  logic              i_axi_rvalid,
  output logic              o_axi_rready,

  axi_rd_arbiter_if.slave   lsu_wr,
  axi_rd_arbiter_if.master  axi_wr,

  output logic              o_proto_err
);

  state_e            state_q, state_d;
  master_e           gnt_q, last_grant_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic [ID_W-1:0]   arid_q;
  logic [7:0]        beat_q;
  logic              proto_err_q;

  logic grant_ifu, grant_lsu, r_hs, route_ifu, route_lsu, err_hit;

  // On a tie the master that did not win last time gets the bus.
  assign grant_ifu = (state_q == IDLE) && i_ifu_arvalid && (!i_lsu_arvalid || last_grant_q == M_LSU);
  assign grant_lsu = (state_q == IDLE) && i_lsu_arvalid && (!i_ifu_arvalid || last_grant_q == M_IFU);
  assign r_hs      = i_axi_rvalid && o_axi_rready;
  assign err_hit   = r_hs && ((i_axi_rid != arid_q) || (i_axi_rlast != (beat_q == arlen_q)));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_ifu || grant_lsu) state_d = ADDR;
      ADDR:    if (i_axi_arready) state_d = DATA;
      DATA:    if (r_hs && i_axi_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    route_ifu     = (state_q == DATA) && (gnt_q == M_IFU);
    route_lsu     = (state_q == DATA) && (gnt_q == M_LSU);
    o_ifu_arready = grant_ifu;
    o_lsu_arready = grant_lsu;
    o_axi_arvalid = (state_q == ADDR);
    o_axi_rready  = (route_ifu && i_ifu_rready) || (route_lsu && i_lsu_rready);
    o_ifu_rvalid  = route_ifu && i_axi_rvalid;
    o_ifu_rlast   = route_ifu && i_axi_rlast;
    o_ifu_rdata   = route_ifu ? i_axi_rdata : '0;
    o_ifu_rresp   = route_ifu ? i_axi_rresp : AXI_RESP_OKAY;
    o_lsu_rvalid  = route_lsu && i_axi_rvalid;
    o_lsu_rlast   = route_lsu && i_axi_rlast;
    o_lsu_rdata   = route_lsu ? i_axi_rdata : '0;
    o_lsu_rresp   = route_lsu ? i_axi_rresp : AXI_RESP_OKAY;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      gnt_q        <= M_IFU;
      last_grant_q <= M_IFU;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arid_q       <= '0;
      beat_q       <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      if (grant_lsu) begin
        gnt_q     <= M_LSU;
        araddr_q  <= i_lsu_araddr;
        arlen_q   <= i_lsu_arlen;
        arsize_q  <= i_lsu_arsize;
        arburst_q <= i_lsu_arburst;
        arid_q    <= ID_W'(ID_LSU);
        beat_q    <= '0;
      end else if (grant_ifu) begin
        gnt_q     <= M_IFU;
        araddr_q  <= i_ifu_araddr;
        arlen_q   <= i_ifu_arlen;
        arsize_q  <= i_ifu_arsize;
        arburst_q <= i_ifu_arburst;
        arid_q    <= ID_W'(ID_IFU);
        beat_q    <= '0;
      end
      if (r_hs) begin
        beat_q <= beat_q + 8'd1;
        if (i_axi_rlast) last_grant_q <= gnt_q;
      end
      // Sticky: only reset clears it; the transaction still ends on rlast.
      if (err_hit) proto_err_q <= 1'b1;
    end
  end

  assign o_axi_araddr  = araddr_q;
  assign o_axi_arid    = arid_q;
  assign o_axi_arlen   = arlen_q;
  assign o_axi_arsize  = arsize_q;
  assign o_axi_arburst = arburst_q;
  assign o_proto_err   = proto_err_q;

  assign axi_wr.awaddr  = lsu_wr.awaddr;
  assign axi_wr.awid    = lsu_wr.awid;
  assign axi_wr.awlen   = lsu_wr.awlen;
  assign axi_wr.awsize  = lsu_wr.awsize;
  assign axi_wr.awburst = lsu_wr.awburst;
  assign axi_wr.awvalid = lsu_wr.awvalid;
  assign axi_wr.wdata   = lsu_wr.wdata;
  assign axi_wr.wstrb   = lsu_wr.wstrb;
  assign axi_wr.wlast   = lsu_wr.wlast;
  assign axi_wr.wvalid  = lsu_wr.wvalid;
  assign axi_wr.bready  = lsu_wr.bready;
  assign lsu_wr.awready = axi_wr.awready;
  assign lsu_wr.wready  = axi_wr.wready;
  assign lsu_wr.bid     = axi_wr.bid;
  assign lsu_wr.bresp   = axi_wr.bresp;
  assign lsu_wr.bvalid  = axi_wr.bvalid;

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master to one-master AXI4 read arbiter that sits directly upstream of the core's address-decoding crossbar.
- Merges the IFU read port (instruction fetch, bursts allowed) and the LSU read port onto the single AXI master read channel the crossbar consumes.
- The LSU write channels (AW/W/B) pass straight through and are not arbitrated.
- Exactly one read transaction is outstanding at a time; the grant is held until the last R beat has handshaken.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, AXI ID width. Issued arid is 0 for IFU and 1 for LSU.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-low reset (0 = reset), sampled on i_clock rising edge.
- i_ifu_araddr/i_ifu_arlen/i_ifu_arsize/i_ifu_arburst  in  ADDR_W/8/3/2  IFU AR payload.
- i_ifu_arvalid  in  1  IFU read request.
- o_ifu_arready  out  1  IFU request accepted.
- o_ifu_rdata/o_ifu_rresp/o_ifu_rlast/o_ifu_rvalid  out  DATA_W/2/1/1  IFU R channel.
- i_ifu_rready  in  1  IFU R ready.
- i_lsu_araddr/i_lsu_arlen/i_lsu_arsize/i_lsu_arburst/i_lsu_arvalid  in  ADDR_W/8/3/2/1  LSU AR channel.
- o_lsu_arready  out  1  LSU request accepted.
- o_lsu_rdata/o_lsu_rresp/o_lsu_rlast/o_lsu_rvalid  out  DATA_W/2/1/1  LSU R channel.
- i_lsu_rready  in  1  LSU R ready.
- o_axi_araddr/o_axi_arid/o_axi_arlen/o_axi_arsize/o_axi_arburst/o_axi_arvalid  out  ADDR_W/ID_W/8/3/2/1  AR to crossbar.
- i_axi_arready  in  1  crossbar AR ready.
- i_axi_rdata/i_axi_rresp/i_axi_rid/i_axi_rlast/i_axi_rvalid  in  DATA_W/2/ID_W/1/1  R from crossbar.
- o_axi_rready  out  1  R ready to crossbar.
- LSU aw*/w*/b* bundle  in/out  per AXI4  combinational wires in both directions between LSU and o_axi_aw*/w*, i_axi_b*.
- o_proto_err  out  1  sticky flag: rid or rlast mismatch.

Behaviour:
- FSM states:
  - IDLE: no read granted.
  - ADDR: o_axi_arvalid=1.
  - DATA: routing R beats.
- Reset (i_reset=0), applied on the next edge, including mid-burst:
  - state=IDLE; all o_axi_ar*, o_*_arready, o_*_rvalid, o_*_rlast, o_axi_rready and o_proto_err go to 0.
  - last_grant=IFU; beat counter=0.
  - An in-flight burst is abandoned; downstream is reset by the same reset.
- IDLE:
  - Only IFU requests: grant IFU. Only LSU requests: grant LSU.
  - Both request: grant the master that is not last_grant (round-robin), so after reset LSU wins the first tie.
  - Grant cycle: o_<granted>_arready=1 combinationally for that cycle only. Payload is latched into registers, arid=0 for IFU / 1 for LSU, beat counter cleared, next state ADDR.
  - The non-granted arready stays 0.
- ADDR:
  - o_axi_ar* driven from the registers; o_axi_arvalid=1 first appears the cycle after acceptance (1-cycle latency).
  - Payload is held stable until i_axi_arready=1, then next state DATA.
- DATA:
  - o_axi_rready = granted master's rready.
  - Granted o_*_rvalid/rdata/rresp/rlast = i_axi_r* combinationally.
  - Non-granted o_*_rvalid=0, rlast=0, rdata=0.
  - Each rvalid&rready increments the 8-bit beat counter.
  - On a handshake with i_axi_rlast=1: next state IDLE, last_grant=granted. The new arbitration happens the following cycle, so the minimum gap between transactions is 1 cycle.
- o_proto_err is set, and stays set until reset, on any handshake with:
  - i_axi_rid != issued ID; or
  - i_axi_rlast=1 while counter != arlen; or
  - i_axi_rlast=0 while counter == arlen.
  - The FSM still ends the transaction only on rlast.
- Arbitration edge cases:
  - A request deasserted before its grant is simply not granted (no latching).
  - arvalid held while another master is being served waits without starvation: after the current transaction it wins by round-robin.
- Write passthrough is independent: a concurrent LSU write and an IFU read are legal.

Decomposition:
- Shared package axi_arb_pkg:
  - state enum {IDLE, ADDR, DATA};
  - localparams ID_IFU=0, ID_LSU=1, AXI_RESP_OKAY=2'b00;
  - width localparams ADDR_W, DATA_W, ID_W.
- No sub-module: single module, roughly 200 lines.

Test Plan:
- IFU alone, araddr=0x8000_0000, arlen=3 → o_ifu_arready pulse at cycle 0; o_axi_arvalid with arid=0 at cycle 1; 4 beats routed to IFU; o_lsu_rvalid stays 0; back in IDLE after beat 4.
- IFU and LSU assert arvalid in the same cycle right after reset → LSU granted (arid=1); IFU granted next with arid=0; a third simultaneous tie → LSU.
- During an IFU burst with arlen=7, i_ifu_rready toggled 1/0 → o_axi_rready follows it; exactly 8 handshakes; o_proto_err=0.
- Crossbar returns rlast on beat 2 of an arlen=3 burst, or rid=1 during an IFU grant → o_proto_err=1 and stays set; FSM returns to IDLE after rlast.
- Reset asserted mid-burst (after beat 1 of an arlen=3 burst) → next cycle: state IDLE, all valids/readies 0; a new LSU request is accepted normally after reset release.
- LSU write to 0xa00003f8 issued during an IFU read → AW/W/B pass through unchanged; IFU read data remains correct.
